// File: rtl/imem_arbiter.sv
// Two-requester arbiter in front of a single-outstanding, fixed-latency instruction memory.
// Response routing follows the owner of the outstanding request; stray responses are flagged.
module imem_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_valid_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_ready_o,
  output logic        m0_valid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m0_ready_i,
  input  logic        m1_valid_i,
  input  logic [31:0] m1_addr_i,
  output logic        m1_ready_o,
  output logic        m1_valid_o,
  output logic [31:0] m1_rdata_o,
  input  logic        m1_ready_i,
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_rsp_ready_o,
  output logic        err_o
);

  logic busy_q, busy_d;
  logic owner_q, owner_d;
  logic last_q, last_d;
  logic err_q, err_d;

  logic rsp_ready;
  logic rsp_hs;
  logic slot_free;
  logic req_ok;
  logic grant;
  logic winner;

  // Winner selection from current requests and last grant only (no path through ready outputs).
  always_comb begin
    winner = 1'b0;
    if (m0_valid_i && m1_valid_i) begin
      if (RR_EN == 1'b1) begin
        winner = ~last_q;
      end else begin
        winner = 1'b0;
      end
    end else if (m1_valid_i) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end

  // Response backpressure comes from the owner; an idle arbiter drains stray responses.
  always_comb begin
    rsp_ready = 1'b1;
    if (busy_q) begin
      case (owner_q)
        1'b0:    rsp_ready = m0_ready_i;
        1'b1:    rsp_ready = m1_ready_i;
        default: rsp_ready = 1'b0;
      endcase
    end else begin
      rsp_ready = 1'b1;
    end
  end

  // Request path; reset masks the grant so nothing leaves while rst_ni is low.
  always_comb begin
    rsp_hs      = mem_rsp_valid_i & rsp_ready;
    slot_free   = ~busy_q | rsp_hs;
    req_ok      = rst_ni & slot_free & (m0_valid_i | m1_valid_i);
    grant       = req_ok & mem_ready_i;
    mem_valid_o = req_ok;
    mem_addr_o  = winner ? m1_addr_i : m0_addr_i;
    m0_ready_o  = req_ok & mem_ready_i & ~winner;
    m1_ready_o  = req_ok & mem_ready_i & winner;
  end

  // Response routing to the owning requester.
  always_comb begin
    mem_rsp_ready_o = rsp_ready;
    m0_valid_o      = mem_rsp_valid_i & busy_q & ~owner_q;
    m1_valid_o      = mem_rsp_valid_i & busy_q & owner_q;
    m0_rdata_o      = mem_rdata_i;
    m1_rdata_o      = mem_rdata_i;
    err_o           = err_q;
  end

  // Next-state: a grant in the same cycle as a response keeps the slot busy for back-to-back fetches.
  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    busy_d  = busy_q;
    err_d   = err_q;
    if (grant) begin
      busy_d  = 1'b1;
      owner_d = winner;
      last_d  = winner;
    end else if (rsp_hs) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (mem_rsp_valid_i && !busy_q) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State register; last_q resets to 1 so port 0 wins the first round-robin tie.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: round-robin and fixed-priority instances share stimulus;
// a 1-cycle memory model answers grants and a queue scoreboards routed responses.
module tb_imem_arbiter;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        m0_valid_i, m0_ready_i, m1_valid_i, m1_ready_i;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic        mem_ready_i, mem_rsp_valid_i;
  logic [31:0] mem_rdata_i;

  logic        m0_ready_o, m0_valid_o, m1_ready_o, m1_valid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o, mem_addr_o;
  logic        mem_valid_o, mem_rsp_ready_o, err_o;

  logic        f_m0_ready_o, f_m0_valid_o, f_m1_ready_o, f_m1_valid_o;
  logic [31:0] f_m0_rdata_o, f_m1_rdata_o, f_mem_addr_o;
  logic        f_mem_valid_o, f_mem_rsp_ready_o, f_err_o;

  int vectors = 0;
  int errors  = 0;
  logic auto_mem;
  logic [32:0] exp_q[$];
  int f0_cnt, f1_cnt;

  always #5 clk = ~clk;

  imem_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk_i(clk), .rst_ni(rst_ni),
    .m0_valid_i(m0_valid_i), .m0_addr_i(m0_addr_i), .m0_ready_o(m0_ready_o),
    .m0_valid_o(m0_valid_o), .m0_rdata_o(m0_rdata_o), .m0_ready_i(m0_ready_i),
    .m1_valid_i(m1_valid_i), .m1_addr_i(m1_addr_i), .m1_ready_o(m1_ready_o),
    .m1_valid_o(m1_valid_o), .m1_rdata_o(m1_rdata_o), .m1_ready_i(m1_ready_i),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i),
    .mem_rsp_ready_o(mem_rsp_ready_o), .err_o(err_o)
  );

  imem_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk_i(clk), .rst_ni(rst_ni),
    .m0_valid_i(m0_valid_i), .m0_addr_i(m0_addr_i), .m0_ready_o(f_m0_ready_o),
    .m0_valid_o(f_m0_valid_o), .m0_rdata_o(f_m0_rdata_o), .m0_ready_i(m0_ready_i),
    .m1_valid_i(m1_valid_i), .m1_addr_i(m1_addr_i), .m1_ready_o(f_m1_ready_o),
    .m1_valid_o(f_m1_valid_o), .m1_rdata_o(f_m1_rdata_o), .m1_ready_i(m1_ready_i),
    .mem_valid_o(f_mem_valid_o), .mem_addr_o(f_mem_addr_o), .mem_ready_i(mem_ready_i),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i),
    .mem_rsp_ready_o(f_mem_rsp_ready_o), .err_o(f_err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge: scoreboard any response handshake seen on the round-robin instance.
  task automatic chk_rsp();
    logic [32:0] got;
    logic [32:0] want;
    chk("rsp_one_hot", {63'd0, m0_valid_o & m1_valid_o}, 64'd0);
    if ((m0_valid_o && m0_ready_i) || (m1_valid_o && m1_ready_i)) begin
      got = (m1_valid_o && m1_ready_i) ? {1'b1, m1_rdata_o} : {1'b0, m0_rdata_o};
      chk("rsp_expected", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        chk("rsp_port_data", {31'd0, got}, {31'd0, want});
      end
    end
  endtask

  // Advance one clock; the memory model answers each accepted request one cycle later.
  task automatic step();
    logic        g;
    logic        d;
    logic [31:0] ga;
    g  = mem_valid_o && mem_ready_i;
    ga = mem_addr_o;
    d  = mem_rsp_valid_i && mem_rsp_ready_o;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      if (g) begin
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = ga ^ KEY;
      end else if (d) begin
        mem_rsp_valid_i = 1'b0;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    chk_rsp();
  endtask

  task automatic do_reset();
    rst_ni          = 1'b0;
    m0_valid_i      = 1'b0;
    m1_valid_i      = 1'b0;
    mem_rsp_valid_i = 1'b0;
    settle();
    step();
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0; auto_mem = 1'b1;
    m0_valid_i = 1'b1; m0_addr_i = 32'h0000_0044; m0_ready_i = 1'b1;
    m1_valid_i = 1'b0; m1_addr_i = 32'h0; m1_ready_i = 1'b1;
    mem_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rdata_i = 32'h0;

    // Reset holds everything quiet even with a request pending
    settle();
    chk("rst_mem_valid", {63'd0, mem_valid_o}, 64'd0);
    chk("rst_m0_ready", {63'd0, m0_ready_o}, 64'd0);
    step();
    settle();
    chk("rst_err", {63'd0, err_o}, 64'd0);
    chk("rst_rsp_valids", {62'd0, m1_valid_o, m0_valid_o}, 64'd0);
    chk("rst_mem_valid2", {63'd0, mem_valid_o}, 64'd0);
    m0_valid_i = 1'b0;
    step();
    rst_ni = 1'b1;

    // Single request from port 0
    m0_valid_i = 1'b1; m0_addr_i = 32'h0000_0010;
    exp_q.push_back({1'b0, 32'h0000_0010 ^ KEY});
    settle();
    chk("single_mem_valid", {63'd0, mem_valid_o}, 64'd1);
    chk("single_mem_addr", {32'd0, mem_addr_o}, {32'd0, 32'h0000_0010});
    chk("single_ready", {62'd0, m1_ready_o, m0_ready_o}, 64'd1);
    step();
    m0_valid_i = 1'b0;
    settle();
    chk("single_rsp_m0", {63'd0, m0_valid_o}, 64'd1);
    chk("single_rsp_m1", {63'd0, m1_valid_o}, 64'd0);
    step();
    settle();
    chk("single_done", {62'd0, m1_valid_o, m0_valid_o}, 64'd0);
    step();

    // Round-robin tie on u_rr; fixed priority on u_fp sees the same traffic
    do_reset();
    m0_valid_i = 1'b1; m0_addr_i = 32'h0000_0100;
    m1_valid_i = 1'b1; m1_addr_i = 32'h0000_0200;
    f0_cnt = 0; f1_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      logic        p;
      logic [31:0] a;
      p = k[0];
      a = p ? 32'h0000_0200 : 32'h0000_0100;
      exp_q.push_back({p, a ^ KEY});
      settle();
      chk("rr_mem_valid", {63'd0, mem_valid_o}, 64'd1);
      chk("rr_mem_addr", {32'd0, mem_addr_o}, {32'd0, a});
      chk("rr_ready", {62'd0, m1_ready_o, m0_ready_o}, p ? 64'd2 : 64'd1);
      chk("fp_mem_addr", {32'd0, f_mem_addr_o}, {32'd0, 32'h0000_0100});
      if (f_mem_valid_o && mem_ready_i) begin
        f0_cnt += int'(f_m0_ready_o);
        f1_cnt += int'(f_m1_ready_o);
      end
      step();
    end
    chk("fp_m0_grants", 64'(f0_cnt), 64'd6);
    chk("fp_m1_grants", 64'(f1_cnt), 64'd0);
    m0_valid_i = 1'b0; m1_valid_i = 1'b0;
    settle();
    chk("rr_drain_idle", {63'd0, mem_valid_o}, 64'd0);
    step();
    settle();
    step();

    // Owner stall blocks the next grant and holds response data
    m0_valid_i = 1'b1; m0_addr_i = 32'h0000_0300; m0_ready_i = 1'b0;
    exp_q.push_back({1'b0, 32'h0000_0300 ^ KEY});
    settle();
    chk("stall_grant", {63'd0, mem_valid_o}, 64'd1);
    step();
    m0_valid_i = 1'b0; m1_valid_i = 1'b1; m1_addr_i = 32'h0000_0400;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("stall_mem_valid", {63'd0, mem_valid_o}, 64'd0);
      chk("stall_m1_ready", {63'd0, m1_ready_o}, 64'd0);
      chk("stall_rsp_valid", {63'd0, m0_valid_o}, 64'd1);
      chk("stall_rsp_data", {32'd0, m0_rdata_o}, {32'd0, 32'h0000_0300 ^ KEY});
      chk("stall_rsp_ready", {63'd0, mem_rsp_ready_o}, 64'd0);
      step();
    end
    m0_ready_i = 1'b1;
    exp_q.push_back({1'b1, 32'h0000_0400 ^ KEY});
    settle();
    chk("unstall_grant", {62'd0, m1_ready_o, mem_valid_o}, 64'd3);
    chk("unstall_addr", {32'd0, mem_addr_o}, {32'd0, 32'h0000_0400});
    step();
    m1_valid_i = 1'b0;
    settle();
    step();

    // Stray response while idle sets the sticky error
    auto_mem = 1'b0;
    do_reset();
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    settle();
    chk("stray_err_before", {63'd0, err_o}, 64'd0);
    chk("stray_rsp_valids", {62'd0, m1_valid_o, m0_valid_o}, 64'd0);
    chk("stray_drain", {63'd0, mem_rsp_ready_o}, 64'd1);
    step();
    mem_rsp_valid_i = 1'b0;
    settle();
    chk("stray_err_set", {63'd0, err_o}, 64'd1);
    step();
    settle();
    chk("stray_err_sticky", {63'd0, err_o}, 64'd1);
    step();
    auto_mem = 1'b1;

    // Reset with a request outstanding abandons it; its late response becomes stray
    do_reset();
    m0_valid_i = 1'b1; m0_addr_i = 32'h0000_0500; m0_ready_i = 1'b0;
    settle();
    chk("mid_grant", {63'd0, mem_valid_o}, 64'd1);
    step();
    rst_ni = 1'b0; m0_valid_i = 1'b0;
    settle();
    step();
    rst_ni = 1'b1; m0_ready_i = 1'b1;
    settle();
    chk("mid_busy_clear", {63'd0, u_rr.busy_q}, 64'd0);
    chk("mid_mem_valid", {63'd0, mem_valid_o}, 64'd0);
    chk("mid_rsp_valids", {62'd0, m1_valid_o, m0_valid_o}, 64'd0);
    step();
    settle();
    chk("mid_err_stray", {63'd0, err_o}, 64'd1);
    step();
    m0_valid_i = 1'b1; m0_addr_i = 32'h0000_0600;
    exp_q.push_back({1'b0, 32'h0000_0600 ^ KEY});
    settle();
    chk("post_grant", {62'd0, m0_ready_o, mem_valid_o}, 64'd3);
    chk("post_addr", {32'd0, mem_addr_o}, {32'd0, 32'h0000_0600});
    step();
    m0_valid_i = 1'b0;
    settle();
    step();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin between requesters, 0 = fixed priority with port 0 winning.
REQ-002 Port: clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_ni  in  1  synchronous, active-low reset.
REQ-004 Ports: m0_valid_i in 1, m0_addr_i in 32, m0_ready_o out 1; requester 0 request channel (fetch unit).
REQ-005 Ports: m0_valid_o out 1, m0_rdata_o out 32, m0_ready_i in 1; requester 0 response channel.
REQ-006 Ports: m1_valid_i, m1_addr_i, m1_ready_o, m1_valid_o, m1_rdata_o, m1_ready_i; requester 1 (debug/loader), same widths and meanings as port 0.
REQ-007 Ports: mem_valid_o out 1, mem_addr_o out 32, mem_ready_i in 1; request channel to instruction memory.
REQ-008 Ports: mem_rsp_valid_i in 1, mem_rdata_i in 32, mem_rsp_ready_o out 1; response channel from instruction memory (fixed 1-cycle latency, in order).
REQ-009 Port: err_o  out  1  sticky flag for an unexpected memory response.

Function
REQ-010 Internal state: busy_q (one request outstanding), owner_q (0/1, owner of the outstanding request), last_q (last granted port).
REQ-011 Slot free: slot_free = !busy_q OR (mem_rsp_valid_i AND mem_rsp_ready_o); at most one outstanding request at any time.
REQ-012 Grant: a grant occurs when slot_free, mem_ready_i and at least one mX_valid_i are all high; no grant occurs otherwise.
REQ-013 Winner, only one valid: that port wins.
REQ-014 Winner, both valid, RR_EN=1: the port opposite last_q wins.
REQ-015 Winner, both valid, RR_EN=0: port 0 wins.
REQ-016 Request path, combinational: mem_valid_o = grant-eligible request present; mem_addr_o = winner's addr; winner's mX_ready_o = slot_free AND mem_ready_i; loser's mX_ready_o = 0.
REQ-017 Arbitration is stable: the winner is computed from current inputs and registered state only, with no combinational loop through mX_ready_o.
REQ-018 Grant cycle updates: busy_q<=1, owner_q<=winner, last_q<=winner.
REQ-019 Response handshake without a simultaneous grant: busy_q<=0.
REQ-020 Response handshake with a simultaneous grant: busy_q stays 1 and owner_q takes the new winner (back-to-back, full throughput).
REQ-021 Response routing: mX_valid_o = mem_rsp_valid_i AND busy_q AND (owner_q==X).
REQ-022 Response backpressure: mem_rsp_ready_o = owner's mX_ready_i when busy_q; mem_rsp_ready_o = 1 when !busy_q, so stray responses are drained.
REQ-023 Response data: m0_rdata_o and m1_rdata_o both equal mem_rdata_i; the non-owner's valid stays low.
REQ-024 Owner stalls (mX_ready_i=0): response is held, busy_q holds, and no new grant is issued.
REQ-025 Stray response (mem_rsp_valid_i while !busy_q): dropped, err_o<=1; err_o clears only on reset.
REQ-026 A requester deasserting valid without a handshake is not an error; arbitration re-evaluates every cycle.

Reset
REQ-027 While rst_ni=0 at a rising edge: busy_q=0, owner_q=0, last_q=1 (port 0 wins the first RR tie), err_o=0.
REQ-028 During reset: all mX_valid_o=0 and mem_valid_o=0 from the first edge with rst_ni=0, regardless of inputs.
REQ-029 Reset asserted with a request outstanding: the outstanding request is abandoned; its later response is treated as stray per REQ-025.

Verification
REQ-030 Single request: m0 requests addr 0x0000_0010, mem_ready_i=1 -> mem_valid_o=1, mem_addr_o=0x10 in the same cycle; next cycle m0_valid_o=1 with mem_rdata_i; m1_valid_o=0.
REQ-031 RR tie: RR_EN=1, both valid continuously (m0 0x100, m1 0x200), owners always ready -> grants alternate m0,m1,m0,m1 with one grant per cycle after the first.
REQ-032 Fixed priority: RR_EN=0, both valid for 4 cycles -> four grants to m0, zero to m1.
REQ-033 Response stall: m0 outstanding, m0_ready_i=0 for 3 cycles, m1_valid_i=1 -> mem_valid_o=0 and m1_ready_o=0 for those 3 cycles; response data stable; m1 granted in the cycle m0_ready_i=1.
REQ-034 Stray response: after reset with no requests, pulse mem_rsp_valid_i=1 -> err_o=1 from the next cycle; both mX_valid_o stay 0.
REQ-035 Mid-operation reset: rst_ni=0 for one cycle while busy_q=1 -> next cycle busy_q=0 and mem_valid_o=0; a following m0 request is granted normally.
